nios2_debug_mem_arbiter: RTL and testbench

NIOS2_DEBUG_MEM_ARBITER -- requirements
Module: nios2_debug_mem_arbiter

---
 rtl/nios2_debug_mem_arbiter_if.sv | 53 +++++
 rtl/nios2_debug_mem_arbiter.sv | 105 ++++++++++
 tb/tb_nios2_debug_mem_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nios2_debug_mem_arbiter_if.sv
// Shared debug-memory bus bundle: JTAG and CPU-monitor requesters, memory port, and status.
// The slave modport is the arbiter's view; the master modport is the requesters/memory side.
interface nios2_debug_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              debugack;

  logic              j_req;
  logic              j_wr;
  logic [ADDR_W-1:0] j_addr;
  logic [DATA_W-1:0] j_wdata;
  logic              j_ack;
  logic [DATA_W-1:0] j_rdata;

  logic              c_req;
  logic              c_wr;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_ack;
  logic [DATA_W-1:0] c_rdata;

  logic              mem_cs;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              last_grant;

  modport slave (
    input  debugack,
    input  j_req, j_wr, j_addr, j_wdata,
    output j_ack, j_rdata,
    input  c_req, c_wr, c_addr, c_wdata,
    output c_ack, c_rdata,
    output mem_cs, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy, last_grant
  );

  modport master (
    output debugack,
    output j_req, j_wr, j_addr, j_wdata,
    input  j_ack, j_rdata,
    output c_req, c_wr, c_addr, c_wdata,
    input  c_ack, c_rdata,
    input  mem_cs, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy, last_grant
  );
endinterface

// File: rtl/nios2_debug_mem_arbiter.sv
// Two-requester (JTAG / CPU monitor) arbiter for a single-port debug memory.
// Write ack 2 cycles after the grant sample, read ack 3; one transaction outstanding at a time.
module nios2_debug_mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  nios2_debug_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_wr;
  logic              r_who;
  logic              r_last_grant;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_j_rdata;
  logic [DATA_W-1:0] r_c_rdata;

  logic              w_any;
  logic              w_pick_j;
  logic              w_grant;

  assign w_any    = bus.j_req | bus.c_req;
  // On a tie without debugack, the requester not granted last time wins.
  assign w_pick_j = bus.j_req & (bus.debugack | ~bus.c_req | ~r_last_grant);
  assign w_grant  = (r_state == IDLE) & w_any;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    bus.mem_cs     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.j_ack      = 1'b0;
    bus.c_ack      = 1'b0;
    bus.busy       = 1'b1;
    case (r_state)
      IDLE: begin
        bus.busy = 1'b0;
        if (w_any) w_next = ISSUE;
      end
      ISSUE: begin
        bus.mem_cs = 1'b1;
        bus.mem_we = r_wr;
        w_next     = r_wr ? DONE : WAIT;
      end
      WAIT: begin
        w_next = DONE;
      end
      DONE: begin
        bus.j_ack = r_who;
        bus.c_ack = ~r_who;
        w_next    = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr         <= 1'b0;
      r_who        <= 1'b0;
      r_last_grant <= 1'b1;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else if (w_grant) begin
      r_who        <= w_pick_j;
      r_last_grant <= w_pick_j;
      r_wr         <= w_pick_j ? bus.j_wr    : bus.c_wr;
      r_addr       <= w_pick_j ? bus.j_addr  : bus.c_addr;
      r_wdata      <= w_pick_j ? bus.j_wdata : bus.c_wdata;
    end
  end

  // Read data lands one cycle after the select, i.e. during WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_j_rdata <= '0;
      r_c_rdata <= '0;
    end else if (r_state == WAIT) begin
      if (r_who) r_j_rdata <= bus.mem_rdata;
      else       r_c_rdata <= bus.mem_rdata;
    end
  end

  assign bus.mem_addr   = r_addr;
  assign bus.mem_wdata  = r_wdata;
  assign bus.j_rdata    = r_j_rdata;
  assign bus.c_rdata    = r_c_rdata;
  assign bus.last_grant = r_last_grant;

endmodule

// File: tb/tb_nios2_debug_mem_arbiter.sv
// Self-checking bench for nios2_debug_mem_arbiter: vector table plus hand-written corner sequences,
// with a memory model and scoreboard queues for memory accesses and acks.
module tb_nios2_debug_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nios2_debug_mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  nios2_debug_mem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic        who;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic        who;
    logic [31:0] rdata;
  } ack_exp_t;

  typedef struct {
    logic        is_j;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          exp_lat;
    logic [31:0] exp_rdata;
  } vec_t;

  mem_exp_t mem_q[$];
  ack_exp_t ack_q[$];

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  // Memory model: read data valid only in the cycle after a read select, junk otherwise.
  logic [31:0] mem [256];
  logic        mem_loaded = 1'b0;
  int          cyc_cnt = 0;
  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (!mem_loaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[8'h22] <= 32'h1234_5678;
      mem[8'hFF] <= 32'hA5A5_5A5A;
      mem_loaded <= 1'b1;
      bus.mem_rdata <= 32'hBADB_AD00;
    end else if (bus.mem_cs && bus.mem_we) begin
      mem[bus.mem_addr] <= bus.mem_wdata;
      bus.mem_rdata <= 32'hBADB_AD00 ^ cyc_cnt;
    end else if (bus.mem_cs) begin
      bus.mem_rdata <= mem[bus.mem_addr];
    end else begin
      bus.mem_rdata <= 32'hBADB_AD00 ^ cyc_cnt;
    end
  end

  // Monitor: pops scoreboard entries as the DUT produces memory accesses and acks.
  always @(negedge clk) begin
    if (!rst) begin
      if (!bus.mem_cs) check("mem_we_without_cs", {31'b0, bus.mem_we}, 32'h0);
      if (bus.mem_cs) begin
        if (mem_q.size() == 0) begin
          flag("unexpected_mem_cs");
        end else begin
          mem_exp_t m;
          m = mem_q.pop_front();
          check("mem_we", {31'b0, bus.mem_we}, {31'b0, m.we});
          check("mem_addr", {24'b0, bus.mem_addr}, {24'b0, m.addr});
          check("mem_wdata", bus.mem_wdata, m.wdata);
          check("last_grant", {31'b0, bus.last_grant}, {31'b0, m.who});
        end
      end
      if (bus.j_ack && bus.c_ack) flag("both_acks_high");
      if (bus.j_ack || bus.c_ack) begin
        if (ack_q.size() == 0) begin
          flag("unexpected_ack");
        end else begin
          ack_exp_t a;
          a = ack_q.pop_front();
          check("ack_who", {31'b0, bus.j_ack}, {31'b0, a.who});
          check("rdata", a.who ? bus.j_rdata : bus.c_rdata, a.rdata);
        end
      end
    end
  end

  task automatic push_exp(input logic who, input logic we, input logic [7:0] addr,
                          input logic [31:0] wdata, input logic push_ack, input logic [31:0] rdata);
    mem_exp_t m;
    ack_exp_t a;
    m.who = who; m.we = we; m.addr = addr; m.wdata = wdata;
    mem_q.push_back(m);
    if (push_ack) begin
      a.who = who; a.rdata = rdata;
      ack_q.push_back(a);
    end
  endtask

  task automatic wait_ack(output int cyc, output logic is_j);
    cyc  = 0;
    is_j = 1'b0;
    while (cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.j_ack || bus.c_ack) begin
        is_j = bus.j_ack;
        return;
      end
    end
    flag("ack_timeout");
    cyc = -1;
  endtask

  task automatic set_req(input logic is_j, input logic wr, input logic [7:0] addr,
                         input logic [31:0] wdata);
    if (is_j) begin
      bus.j_wr = wr; bus.j_addr = addr; bus.j_wdata = wdata; bus.j_req = 1'b1;
    end else begin
      bus.c_wr = wr; bus.c_addr = addr; bus.c_wdata = wdata; bus.c_req = 1'b1;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  vec_t vecs[8];
  int   cyc;
  logic got_j;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 8'h10, 32'hDEAD_BEEF, 2, 32'h0000_0000};
    vecs[1] = '{1'b1, 1'b0, 8'h22, 32'h0000_0000, 3, 32'h1234_5678};
    vecs[2] = '{1'b1, 1'b1, 8'h22, 32'hCAFE_F00D, 2, 32'h1234_5678};
    vecs[3] = '{1'b1, 1'b0, 8'h22, 32'h0000_0000, 3, 32'hCAFE_F00D};
    vecs[4] = '{1'b0, 1'b0, 8'h10, 32'h0000_0000, 3, 32'hDEAD_BEEF};
    vecs[5] = '{1'b0, 1'b1, 8'h05, 32'h0000_0001, 2, 32'hDEAD_BEEF};
    vecs[6] = '{1'b0, 1'b0, 8'hFF, 32'h1111_1111, 3, 32'hA5A5_5A5A};
    vecs[7] = '{1'b1, 1'b0, 8'h05, 32'h2222_2222, 3, 32'h0000_0001};

    bus.debugack = 1'b0;
    bus.j_req = 1'b0; bus.j_wr = 1'b0; bus.j_addr = '0; bus.j_wdata = '0;
    bus.c_req = 1'b0; bus.c_wr = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_cs", {31'b0, bus.mem_cs}, 32'h0);
    check("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
    check("rst_acks", {30'b0, bus.j_ack, bus.c_ack}, 32'h0);
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_last_grant", {31'b0, bus.last_grant}, 32'h1);
    check("rst_j_rdata", bus.j_rdata, 32'h0);
    check("rst_c_rdata", bus.c_rdata, 32'h0);
    check("rst_mem_addr", {24'b0, bus.mem_addr}, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-requester transactions from the vector table.
    for (int i = 0; i < 8; i++) begin
      push_exp(vecs[i].is_j, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b1, vecs[i].exp_rdata);
      set_req(vecs[i].is_j, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      wait_ack(cyc, got_j);
      check($sformatf("latency_v%0d", i), cyc, vecs[i].exp_lat);
      bus.j_req = 1'b0;
      bus.c_req = 1'b0;
      @(posedge clk); #1;
      check($sformatf("busy_after_v%0d", i), {31'b0, bus.busy}, 32'h0);
    end

    // Continuous tie after reset: CPU first, then alternating.
    pulse_reset();
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push_exp(1'b0, 1'b1, 8'h31, 32'hC0C0_0031, 1'b1, 32'h0);
      else            push_exp(1'b1, 1'b1, 8'h30, 32'h1A1A_0030, 1'b1, 32'h0);
    end
    set_req(1'b1, 1'b1, 8'h30, 32'h1A1A_0030);
    set_req(1'b0, 1'b1, 8'h31, 32'hC0C0_0031);
    for (int k = 0; k < 4; k++) wait_ack(cyc, got_j);
    bus.j_req = 1'b0;
    bus.c_req = 1'b0;
    @(posedge clk); #1;

    // debugack: JTAG wins every tie; CPU served once JTAG stays low.
    bus.debugack = 1'b1;
    for (int k = 0; k < 3; k++) push_exp(1'b1, 1'b1, 8'h40, 32'h0000_0040, 1'b1, 32'h0);
    push_exp(1'b0, 1'b1, 8'h41, 32'h0000_0041, 1'b1, 32'h0);
    set_req(1'b1, 1'b1, 8'h40, 32'h0000_0040);
    set_req(1'b0, 1'b1, 8'h41, 32'h0000_0041);
    for (int k = 0; k < 3; k++) wait_ack(cyc, got_j);
    bus.j_req = 1'b0;
    wait_ack(cyc, got_j);
    check("debugack_cpu_after_jtag", {31'b0, got_j}, 32'h0);
    bus.c_req = 1'b0;
    bus.debugack = 1'b0;
    @(posedge clk); #1;

    // Reset during WAIT of a CPU read: abandoned, then the held request is serviced.
    push_exp(1'b0, 1'b0, 8'h10, 32'h0, 1'b0, 32'h0);
    set_req(1'b0, 1'b0, 8'h10, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_mem_cs", {31'b0, bus.mem_cs}, 32'h0);
    check("midrst_busy", {31'b0, bus.busy}, 32'h0);
    check("midrst_c_rdata", bus.c_rdata, 32'h0);
    check("midrst_acks", {30'b0, bus.j_ack, bus.c_ack}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    push_exp(1'b0, 1'b0, 8'h10, 32'h0, 1'b1, 32'hDEAD_BEEF);
    wait_ack(cyc, got_j);
    check("post_rst_read_latency", cyc, 3);
    bus.c_req = 1'b0;
    @(posedge clk); #1;

    // CPU drops req during ISSUE of a write: write still lands, one ack.
    push_exp(1'b0, 1'b1, 8'h50, 32'h5555_AAAA, 1'b1, 32'hDEAD_BEEF);
    set_req(1'b0, 1'b1, 8'h50, 32'h5555_AAAA);
    @(posedge clk); #1;
    bus.c_req = 1'b0;
    wait_ack(cyc, got_j);
    check("dropped_req_ack_delay", cyc, 1);
    repeat (4) @(posedge clk);
    #1;
    check("dropped_req_mem_written", mem[8'h50], 32'h5555_AAAA);

    check("mem_q_drained", mem_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
